spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
//  SPI slave receiver (mode 0, MSB first) feeding the VGA text display.
//  Oversamples external sclk/mosi/cs_n in the system clock domain and deframes bytes.
//  Presents each completed byte on spi_data with a one-cycle new_data strobe.
//  Echoes the previously received byte on miso and flags aborted frames.
// PARAMETERS
//  SYNC_STAGES  2   synchronizer flops on sclk, mosi, cs_n (>=2, all equal)
//  CNT_W        8   width of rx_count (wraps)
// PORTS
//  clk         in   1      system clock; sclk freq must be <= clk/8
//  rst         in   1      synchronous, active-high reset
//  sclk        in   1      SPI clock, async to clk, idle low
//  mosi        in   1      SPI data in, async
//  cs_n        in   1      SPI chip select, active low, async
//  miso        out  1      SPI data out (echo of last completed byte)
//  spi_data    out  8      last completed byte, held until next byte
//  new_data    out  1      one-cycle pulse: spi_data just updated
//  frame_err   out  1      one-cycle pulse: cs_n rose with partial byte
//  rx_count    out  CNT_W  completed bytes since reset, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  Reset (rst=1 at posedge clk): spi_data=0, new_data=0, frame_err=0, rx_count=0,
//   miso=0, bit_cnt=0, shift reg=0, echo reg=0, state=RESYNC.
//  Sync: sclk, mosi, cs_n each pass SYNC_STAGES flops; one more flop on sclk_s and
//   cs_n_s gives edge detect. mosi_s sampled in the cycle sclk_s rise is detected.
//  FSM:
//   RESYNC: ignore all edges; cs_n_s=1 -> IDLE. (Reset mid-frame never yields a byte.)
//   IDLE:   cs_n_s falling -> ACTIVE; bit_cnt=0; load echo reg into tx shift.
//   ACTIVE: sclk_s rise -> shift in mosi_s (MSB first), bit_cnt+1 (3-bit, wraps).
//           sclk_s fall -> shift tx left, miso = tx MSB.
//           cs_n_s rise -> IDLE; if bit_cnt!=0 pulse frame_err, discard partial byte.
//  Byte complete: rise detected in cycle N with bit_cnt=7 -> in cycle N+1:
//   spi_data = {shift[6:0],mosi_s}, new_data=1 for exactly one cycle, rx_count+1,
//   echo reg = same byte, bit_cnt=0. Back-to-back bytes need no cs_n toggle.
//  Latency: last sclk pad rise to new_data high = SYNC_STAGES+2 clk cycles.
//  miso: first bit (echo MSB) driven on cs_n_s fall; stays valid across the
//   following sclk rise since updates only follow sclk_s falls.
//  Simultaneous cs_n_s rise and 8th sclk_s rise in same cycle: byte completes
//   (new_data=1), no frame_err, then IDLE.
//  sclk edges while cs_n_s=1: ignored, no state change.
//  Duplicate byte values are always re-strobed; no filtering here.
//  rst mid-operation: outputs cleared next edge; FSM enters RESYNC.
// STRUCTURE
//  spi_pkg: BYTE_W=8, BIT_CNT_W=3, state encoding localparams
//   (ST_RESYNC=2'd0, ST_IDLE=2'd1, ST_ACTIVE=2'd2).
//  Sub-module bit_sync (SYNC_STAGES-deep flop chain, 1-bit), instantiated x3.
//  Remainder (edge detect, FSM, shift/echo regs, counter) flat in spi_slave_rx.
// TESTING  (clk 50 MHz, sclk 5 MHz unless noted)
//  1 rst, cs_n=1, then frame 0xA5 -> one new_data pulse, spi_data=0xA5,
//    rx_count=1, frame_err never set.
//  2 one cs_n low, bytes 0x41,0x42,0x42 -> three pulses, spi_data 0x41,0x42,0x42,
//    rx_count=3; miso on byte 2 shifts out 0x41, on byte 3 shifts out 0x42.
//  3 cs_n low, 5 sclk pulses, cs_n high -> frame_err one pulse, no new_data,
//    spi_data/rx_count unchanged; next full frame 0x3C received correctly.
//  4 rst for one cycle after 3rd bit of a frame, cs_n kept low, 5 more bits,
//    cs_n high, then frame 0x7E -> only one new_data, spi_data=0x7E, rx_count=1.
//  5 sclk toggling 8x with cs_n=1 -> no new_data, no frame_err, miso=0.
//  6 rx_count at 255, one more byte -> rx_count=0, new_data pulses; sclk=clk/8
//    stress with 16 random bytes -> all received in order.

Source files
------------

// File: rtl/spi_slave_rx_pkg.sv
// Shared widths and FSM encoding for the SPI slave receiver.
package spi_slave_rx_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_RESYNC = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

endpackage

// File: rtl/spi_slave_rx_if.sv
// SPI pins plus the received-byte side channel toward the text display.
interface spi_slave_rx_if #(
    parameter int CNT_W = 8
);
    import spi_slave_rx_pkg::*;

    logic              sclk;
    logic              mosi;
    logic              cs_n;
    logic              miso;
    logic [BYTE_W-1:0] spi_data;
    logic              new_data;
    logic              frame_err;
    logic [CNT_W-1:0]  rx_count;

    // The receiver: consumes the SPI pins, produces miso and the byte stream.
    modport slave (
        input  sclk, mosi, cs_n,
        output miso, spi_data, new_data, frame_err, rx_count
    );

    // The SPI master / environment side.
    modport master (
        output sclk, mosi, cs_n,
        input  miso, spi_data, new_data, frame_err, rx_count
    );

endinterface

// File: rtl/spi_slave_rx_bit_sync.sv
// Single-bit synchronizer: STAGES-deep flop chain into the clk domain.
// Deliberately not reset, so a reset mid-frame sees the true pin level
// immediately instead of a fake idle level followed by a fake cs_n edge.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the async input one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer register chain.
    always_ff @(posedge clk) begin
        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver, MSB first, oversampled in the clk domain.
// Delivers each byte with a one-cycle new_data strobe and echoes the
// previous byte back on miso.
module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic           clk,
    input  logic           rst,
    spi_slave_rx_if.slave  bus
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W - 1);

    logic sclk_s, mosi_s, cs_n_s;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .d(bus.sclk), .q(sclk_s));
    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .d(bus.mosi), .q(mosi_s));
    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_cs_n (.clk(clk), .d(bus.cs_n), .q(cs_n_s));

    state_e                state_q, state_d;
    logic                  sclk_prev_q, sclk_prev_d;
    logic                  cs_n_prev_q, cs_n_prev_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]     shift_q, shift_d;
    logic [BYTE_W-1:0]     tx_q, tx_d;
    logic [BYTE_W-1:0]     echo_q, echo_d;
    logic                  miso_q, miso_d;
    logic [BYTE_W-1:0]     spi_data_q, spi_data_d;
    logic                  new_data_q, new_data_d;
    logic                  frame_err_q, frame_err_d;
    logic [CNT_W-1:0]      rx_count_q, rx_count_d;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    assign sclk_rise =  sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s &  sclk_prev_q;
    assign cs_fall   = ~cs_n_s &  cs_n_prev_q;
    assign cs_rise   =  cs_n_s & ~cs_n_prev_q;

    // Next-state: framing FSM, rx/tx shifters, byte delivery and echo.
    always_comb begin
        state_d     = state_q;
        sclk_prev_d = sclk_s;
        cs_n_prev_d = cs_n_s;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        echo_d      = echo_q;
        miso_d      = miso_q;
        spi_data_d  = spi_data_q;
        new_data_d  = 1'b0;
        frame_err_d = 1'b0;
        rx_count_d  = rx_count_q;

        case (state_q)
            // Wait out any frame already in progress when reset was applied.
            ST_RESYNC: begin
                if (cs_n_s) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    // Echo MSB goes out right away; tx then holds the remaining bits.
                    miso_d    = echo_q[BYTE_W-1];
                    tx_d      = {echo_q[BYTE_W-2:0], 1'b0};
                end
            end
            ST_ACTIVE: begin
                if (sclk_rise) begin
                    shift_d   = {shift_q[BYTE_W-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        spi_data_d = shift_d;
                        new_data_d = 1'b1;
                        rx_count_d = rx_count_q + 1'b1;
                        echo_d     = shift_d;
                        // Full byte: its MSB leaves on the next sclk fall.
                        tx_d       = shift_d;
                    end
                end
                if (sclk_fall) begin
                    miso_d = tx_q[BYTE_W-1];
                    tx_d   = {tx_q[BYTE_W-2:0], 1'b0};
                end
                // Evaluated after the rise so an 8th bit landing with cs_n rise still counts.
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    if (bit_cnt_d != '0) frame_err_d = 1'b1;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            default: state_d = ST_RESYNC;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RESYNC;
            sclk_prev_q <= 1'b0;
            cs_n_prev_q <= 1'b1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            echo_q      <= '0;
            miso_q      <= 1'b0;
            spi_data_q  <= '0;
            new_data_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            sclk_prev_q <= sclk_prev_d;
            cs_n_prev_q <= cs_n_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            echo_q      <= echo_d;
            miso_q      <= miso_d;
            spi_data_q  <= spi_data_d;
            new_data_q  <= new_data_d;
            frame_err_q <= frame_err_d;
            rx_count_q  <= rx_count_d;
        end
    end

    assign bus.miso      = miso_q;
    assign bus.spi_data  = spi_data_q;
    assign bus.new_data  = new_data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rx_count  = rx_count_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a byte-queue model of what the master
// sent, checked against the DUT on every clk, plus literal spot checks.
module tb_spi_slave_rx;
    import spi_slave_rx_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;   // 50 MHz

    spi_slave_rx_if #(.CNT_W(CNT_W)) bus ();

    spi_slave_rx #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];        // bytes the master completed, not yet strobed
    int          mdl_cnt  = 0;    // bytes strobed since reset, mod 256
    logic [7:0]  hold_data = 8'h00;
    logic [7:0]  last_byte = 8'h00; // byte the slave must echo
    int          ferr_pend = 0;
    int          half_ns   = 100;  // 5 MHz sclk
    logic        nd_prev   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the byte-queue model.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.new_data) begin
                check("new_data_width", int'(nd_prev), 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_new_data: got byte 0x%0h, expected none", bus.spi_data);
                end else begin
                    mdl_cnt   = (mdl_cnt + 1) % 256;
                    hold_data = exp_q.pop_front();
                    check("spi_data", int'(bus.spi_data), int'(hold_data));
                    check("rx_count", int'(bus.rx_count), mdl_cnt);
                end
            end else begin
                check("spi_data_hold", int'(bus.spi_data), int'(hold_data));
                check("rx_count_hold", int'(bus.rx_count), mdl_cnt);
            end
            if (bus.frame_err) begin
                n_checks++;
                if (ferr_pend == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame_err: got 1, expected 0 at %0t", $time);
                end else begin
                    ferr_pend--;
                end
            end
        end
        nd_prev <= bus.new_data;
    end

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        mdl_cnt   = 0;
        hold_data = 8'h00;
        last_byte = 8'h00;
        ferr_pend = 0;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One sclk period, mode 0: data set while low, master samples miso on rise.
    task automatic xfer_bit(input logic b, input logic exp_miso);
        bus.mosi = b;
        #(half_ns);
        bus.sclk = 1'b1;
        check("miso", int'(bus.miso), int'(exp_miso));
        #(half_ns);
        bus.sclk = 1'b0;
    endtask

    // Send the top nbits of b; a full byte becomes a model expectation.
    task automatic xfer_byte(input logic [7:0] b, input int nbits, input bit expect_byte);
        logic [7:0] echo;
        echo = last_byte;
        if (nbits == 8 && expect_byte) exp_q.push_back(b);
        for (int i = 0; i < nbits; i++) xfer_bit(b[7-i], echo[7-i]);
        if (nbits == 8 && expect_byte) last_byte = b;
    endtask

    task automatic cs_begin();
        bus.cs_n = 1'b0;
        #(half_ns);
    endtask

    task automatic cs_end(input bit expect_ferr);
        #(half_ns);
        if (expect_ferr) ferr_pend++;
        bus.cs_n = 1'b1;
        #(2 * half_ns);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && (exp_q.size() != 0 || ferr_pend != 0); i++) @(negedge clk);
        check(name, exp_q.size() + ferr_pend, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.cs_n = 1'b1;

        // 1: reset state, then a single frame 0xA5
        do_reset(4);
        @(negedge clk);
        check("rst_spi_data",  int'(bus.spi_data),  0);
        check("rst_rx_count",  int'(bus.rx_count),  0);
        check("rst_new_data",  int'(bus.new_data),  0);
        check("rst_frame_err", int'(bus.frame_err), 0);
        check("rst_miso",      int'(bus.miso),      0);
        repeat (4) @(negedge clk);
        cs_begin();
        xfer_byte(8'hA5, 8, 1);
        cs_end(0);
        drain("t1_drain");
        check("t1_spi_data", int'(bus.spi_data), 'hA5);
        check("t1_rx_count", int'(bus.rx_count), 1);

        // 2: three back-to-back bytes in one frame, echo on miso
        do_reset(2);
        repeat (4) @(negedge clk);
        cs_begin();
        xfer_byte(8'h41, 8, 1);
        xfer_byte(8'h42, 8, 1);
        xfer_byte(8'h42, 8, 1);
        cs_end(0);
        drain("t2_drain");
        check("t2_spi_data", int'(bus.spi_data), 'h42);
        check("t2_rx_count", int'(bus.rx_count), 3);

        // 3: aborted 5-bit frame, then a good frame
        cs_begin();
        xfer_byte(8'hF0, 5, 0);
        cs_end(1);
        drain("t3_ferr_drain");
        check("t3_spi_data_kept", int'(bus.spi_data), 'h42);
        check("t3_rx_count_kept", int'(bus.rx_count), 3);
        cs_begin();
        xfer_byte(8'h3C, 8, 1);
        cs_end(0);
        drain("t3_drain");
        check("t3_spi_data", int'(bus.spi_data), 'h3C);
        check("t3_rx_count", int'(bus.rx_count), 4);

        // 4: reset after 3rd bit, frame continues, then a clean 0x7E frame
        cs_begin();
        xfer_byte(8'hB7, 3, 0);
        do_reset(1);
        xfer_byte(8'h5A, 5, 0);
        cs_end(0);
        cs_begin();
        xfer_byte(8'h7E, 8, 1);
        cs_end(0);
        drain("t4_drain");
        check("t4_spi_data", int'(bus.spi_data), 'h7E);
        check("t4_rx_count", int'(bus.rx_count), 1);

        // 5: sclk activity with cs_n high must be ignored
        do_reset(2);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) xfer_bit(1'b1, 1'b0);
        repeat (8) @(negedge clk);
        check("t5_miso",     int'(bus.miso),     0);
        check("t5_rx_count", int'(bus.rx_count), 0);

        // 6: sclk = clk/8, counter wrap and random stress
        half_ns = 80;
        do_reset(2);
        repeat (4) @(negedge clk);
        cs_begin();
        for (int i = 0; i < 255; i++) begin
            r = 8'($urandom_range(0, 255));
            xfer_byte(r, 8, 1);
        end
        drain("t6_fill_drain");
        check("t6_rx_count_255", int'(bus.rx_count), 255);
        xfer_byte(8'hC3, 8, 1);
        drain("t6_wrap_drain");
        check("t6_rx_count_wrap", int'(bus.rx_count), 0);
        check("t6_spi_data_wrap", int'(bus.spi_data), 'hC3);
        for (int i = 0; i < 16; i++) begin
            r = 8'($urandom_range(0, 255));
            xfer_byte(r, 8, 1);
        end
        cs_end(0);
        drain("t6_stress_drain");
        check("t6_rx_count_end", int'(bus.rx_count), 16);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
